neuron_mac_acc: RTL and testbench

Streaming dot-product neuron that feeds softplus_squared.
- Accepts one (x, w) Q8.8 pair per cycle over a valid/ready handshake.
- Accumulates the products in a wide register, adds a bias, and rescales the result back to Q8.8 with saturation.
- Presents one 16-bit pre-activation operand per vector on a valid/ready output.
- Sits directly upstream of the softplus_squared activation in the VAE encoder and decoder layers.

---
 rtl/vae_fixed_pkg.sv | 21 ++
 rtl/sat_round_q.sv | 48 ++++
 rtl/neuron_mac_acc.sv | 110 +++++++++++
 tb/tb_neuron_mac_acc.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vae_fixed_pkg.sv
// Shared fixed-point definitions for the VAE layer stages (neuron_mac_acc,
// softplus_squared and the mult stage).
//   DATA_W / FRAC_BITS : signed Q8.8 operand format
//   Q_MAX / Q_MIN      : saturation limits of a DATA_W signed value
//   state_e            : neuron accumulator control states
package vae_fixed_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FRAC_BITS = 8;

    localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        ACC,
        DRAIN,
        FINAL,
        OUT
    } state_e;

endpackage

// File: rtl/sat_round_q.sv
// Combinational round / arithmetic-shift / saturate from a wide signed
// accumulator value down to a signed Q8.8 DATA_W result.
// Build option: ROUND_NEAREST_EN adds half an LSB before the shift
// (round-half-up); otherwise the shift truncates toward negative infinity.
// Ports:
//   din  in  ACC_W   signed value with FRAC_BITS fractional bits
//   dout out DATA_W  rounded, shifted, saturated result
//   sat  out 1       dout was clipped to Q_MAX or Q_MIN
module sat_round_q
    import vae_fixed_pkg::*;
#(
    parameter int unsigned ACC_W = 40
) (
    input  logic [ACC_W-1:0]  din,
    output logic [DATA_W-1:0] dout,
    output logic              sat
);

    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] shf;
    logic signed [ACC_W-1:0] max_ext;
    logic signed [ACC_W-1:0] min_ext;

`ifdef ROUND_NEAREST_EN
    logic [ACC_W-1:0] half;
    assign half = {{(ACC_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
    assign rnd  = $signed(din + half);
`else
    assign rnd  = $signed(din);
`endif

    assign shf     = rnd >>> FRAC_BITS;
    assign max_ext = $signed({{(ACC_W-DATA_W){1'b0}}, Q_MAX});
    assign min_ext = $signed({{(ACC_W-DATA_W){1'b1}}, Q_MIN});

    always_comb begin
        dout = shf[DATA_W-1:0];
        sat  = 1'b0;
        if (shf > max_ext) begin
            dout = Q_MAX;
            sat  = 1'b1;
        end else if (shf < min_ext) begin
            dout = Q_MIN;
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/neuron_mac_acc.sv
// Streaming dot-product neuron: accumulates x*w over a vector, adds a bias,
// and emits one saturated Q8.8 pre-activation for softplus_squared.
// DATA_W and FRAC_BITS come from vae_fixed_pkg.
// Build option: ROUND_NEAREST_EN (see sat_round_q); latency is unchanged.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake
//   in_x, in_w          signed Q8.8 activation and weight
//   in_last             final beat of the vector
//   bias                signed Q8.8 bias, sampled with the in_last beat
//   out_valid/out_ready result handshake
//   out_data, out_sat   saturated result and clip flag
module neuron_mac_acc
    import vae_fixed_pkg::*;
#(
    parameter int unsigned ACC_W = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_w,
    input  logic              in_last,
    input  logic [DATA_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat
);

    state_e                  state;
    logic [ACC_W-1:0]        acc;
    logic signed [2*DATA_W-1:0] prod;
    logic                    prod_vld;
    logic [DATA_W-1:0]       bias_reg;

    logic [ACC_W-1:0]        prod_ext;
    logic [ACC_W-1:0]        bias_ext;
    logic [ACC_W-1:0]        sum;
    logic [DATA_W-1:0]       sr_q;
    logic                    sr_sat;

    assign in_ready = (state == ACC);

    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    // Bias is Q8.8; align it to the Q16.16 product scale before adding.
    assign bias_ext = {{(ACC_W-DATA_W){bias_reg[DATA_W-1]}}, bias_reg} << FRAC_BITS;
    assign sum      = acc + bias_ext;

    sat_round_q #(
        .ACC_W (ACC_W)
    ) u_sat_round_q (
        .din  (sum),
        .dout (sr_q),
        .sat  (sr_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            prod      <= '0;
            prod_vld  <= 1'b0;
            bias_reg  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            // prod_vld marks a fresh product, so bubbles never re-add a stale one.
            if (prod_vld) begin
                acc <= acc + prod_ext;
            end
            prod_vld <= 1'b0;

            unique case (state)
                ACC: begin
                    if (in_valid) begin
                        prod     <= $signed(in_x) * $signed(in_w);
                        prod_vld <= 1'b1;
                        if (in_last) begin
                            bias_reg <= bias;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state <= FINAL;
                end
                FINAL: begin
                    out_data  <= sr_q;
                    out_sat   <= sr_sat;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        acc       <= '0;
                        out_valid <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_acc.sv
// Self-checking bench for neuron_mac_acc: directed vector table, reset
// sequences, and random vectors checked against an integer reference model.
module tb_neuron_mac_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_w;
    logic        in_last;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;

    int checks = 0;
    int errors = 0;

    logic [15:0] qx[$];
    logic [15:0] qw[$];
    int          qg[$];

    typedef struct {
        string       name;
        int          n;
        logic [15:0] x[4];
        logic [15:0] w[4];
        int          gap[4];
        logic [15:0] b;
        logic [15:0] ed;
        logic        es;
        int          stall;
    } vec_t;

    vec_t tbl[8];

    neuron_mac_acc #(
        .ACC_W (40)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer dot product, bias scaled to the product format,
    // optional half-LSB, floor division by 2^8, clip to int16.
    task automatic ref_model(input logic [15:0] b, output logic [15:0] d, output logic s);
        longint sum = 0;
        longint q;
        for (int i = 0; i < qx.size(); i++) begin
            sum += longint'($signed(qx[i])) * longint'($signed(qw[i]));
        end
        sum += longint'($signed(b)) * 256;
`ifdef ROUND_NEAREST_EN
        sum += 128;
`endif
        q = sum >>> 8;
        if (q > 32767) begin
            d = 16'h7FFF;
            s = 1'b1;
        end else if (q < -32768) begin
            d = 16'h8000;
            s = 1'b1;
        end else begin
            d = 16'(q);
            s = 1'b0;
        end
    endtask

    // Drives the queued beats; leaves time just after the in_last edge.
    task automatic send_vec(input string name, input logic [15:0] b);
        int wt = 0;
        while (!in_ready && wt < 20) begin
            tick();
            wt++;
        end
        chk({name, "_ready"}, 32'(in_ready), 32'd1);
        for (int i = 0; i < qx.size(); i++) begin
            for (int g = 0; g < qg[i]; g++) begin
                in_valid = 1'b0;
                in_x     = 16'($urandom);
                in_w     = 16'($urandom);
                in_last  = 1'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_x     = qx[i];
            in_w     = qw[i];
            in_last  = (i == qx.size() - 1);
            bias     = (i == qx.size() - 1) ? b : 16'($urandom);
            tick();
        end
    endtask

    // Waits for the result with junk beats offered (must be ignored),
    // checks latency, holds for `stall` cycles, then completes the handshake.
    task automatic finish_vec(input string name, input logic [15:0] ed, input logic es,
                              input int stall);
        int          lat = 0;
        logic [15:0] d0;
        logic        s0;
        in_valid = 1'b1;
        in_x     = 16'($urandom);
        in_w     = 16'($urandom);
        in_last  = 1'($urandom);
        bias     = 16'($urandom);
        while (!out_valid && lat < 8) begin
            tick();
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'd2);
        chk({name, "_data"}, 32'(out_data), 32'(ed));
        chk({name, "_sat"}, 32'(out_sat), 32'(es));
        chk({name, "_busy"}, 32'(in_ready), 32'd0);
        d0 = out_data;
        s0 = out_sat;
        for (int s = 0; s < stall; s++) begin
            tick();
            chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({name, "_hold_data"}, 32'(out_data), 32'(d0));
            chk({name, "_hold_sat"}, 32'(out_sat), 32'(s0));
            chk({name, "_hold_busy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        chk({name, "_done_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_done_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] ed;
        logic        es;
        int          wt;

        // name, n, x, w, gap, bias, expected data, expected sat, stall
        tbl[0] = '{"basic", 2, '{16'h0100, 16'h0200, 0, 0}, '{16'h0080, 16'h0040, 0, 0},
                   '{0, 0, 0, 0}, 16'h0080, 16'h0180, 1'b0, 0};
        tbl[1] = '{"pos_sat", 2, '{16'h7F00, 16'h7F00, 0, 0}, '{16'h7F00, 16'h7F00, 0, 0},
                   '{0, 0, 0, 0}, 16'h0000, 16'h7FFF, 1'b1, 0};
        tbl[2] = '{"neg_sat", 2, '{16'h8100, 16'h8100, 0, 0}, '{16'h7F00, 16'h7F00, 0, 0},
                   '{0, 0, 0, 0}, 16'h0000, 16'h8000, 1'b1, 0};
`ifdef ROUND_NEAREST_EN
        tbl[3] = '{"round_pos", 1, '{16'h0001, 0, 0, 0}, '{16'h0080, 0, 0, 0},
                   '{0, 0, 0, 0}, 16'h0000, 16'h0001, 1'b0, 0};
        tbl[4] = '{"round_neg", 1, '{16'hFFFF, 0, 0, 0}, '{16'h0080, 0, 0, 0},
                   '{0, 0, 0, 0}, 16'h0000, 16'h0000, 1'b0, 0};
`else
        tbl[3] = '{"round_pos", 1, '{16'h0001, 0, 0, 0}, '{16'h0080, 0, 0, 0},
                   '{0, 0, 0, 0}, 16'h0000, 16'h0000, 1'b0, 0};
        tbl[4] = '{"round_neg", 1, '{16'hFFFF, 0, 0, 0}, '{16'h0080, 0, 0, 0},
                   '{0, 0, 0, 0}, 16'h0000, 16'hFFFF, 1'b0, 0};
`endif
        tbl[5] = '{"backpressure", 2, '{16'h0100, 16'h0200, 0, 0},
                   '{16'h0080, 16'h0040, 0, 0}, '{0, 0, 0, 0}, 16'h0080, 16'h0180, 1'b0, 5};
        tbl[6] = '{"after_bp", 1, '{16'h0100, 0, 0, 0}, '{16'h0100, 0, 0, 0},
                   '{0, 0, 0, 0}, 16'h0000, 16'h0100, 1'b0, 0};
        tbl[7] = '{"bubbles", 2, '{16'h0100, 16'h0100, 0, 0}, '{16'h0100, 16'h0100, 0, 0},
                   '{0, 2, 0, 0}, 16'h0000, 16'h0200, 1'b0, 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        in_last   = 1'b0;
        bias      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_sat", 32'(out_sat), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        for (int t = 0; t < 8; t++) begin
            qx.delete();
            qw.delete();
            qg.delete();
            for (int i = 0; i < tbl[t].n; i++) begin
                qx.push_back(tbl[t].x[i]);
                qw.push_back(tbl[t].w[i]);
                qg.push_back(tbl[t].gap[i]);
            end
            send_vec(tbl[t].name, tbl[t].b);
            finish_vec(tbl[t].name, tbl[t].ed, tbl[t].es, tbl[t].stall);
        end

        // Reset after 2 of 4 beats; out_data is non-zero from the last vector.
        in_valid = 1'b1;
        in_x     = 16'h0100;
        in_w     = 16'h0100;
        in_last  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_out_data", 32'(out_data), 32'd0);
        chk("rst_mid_out_sat", 32'(out_sat), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        qx = '{16'h0300};
        qw = '{16'h0100};
        qg = '{0};
        send_vec("rst_mid_next", 16'h0000);
        finish_vec("rst_mid_next", 16'h0300, 1'b0, 0);

        // Reset while a saturated result is waiting in OUT.
        qx = '{16'h7F00, 16'h7F00};
        qw = '{16'h7F00, 16'h7F00};
        qg = '{0, 0};
        send_vec("rst_out", 16'h0000);
        in_valid = 1'b0;
        wt = 0;
        while (!out_valid && wt < 8) begin
            tick();
            wt++;
        end
        chk("rst_out_reached", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_out_in_ready", 32'(in_ready), 32'd1);
        qx = '{16'h0100};
        qw = '{16'h0100};
        qg = '{0};
        send_vec("rst_out_next", 16'h0000);
        finish_vec("rst_out_next", 16'h0100, 1'b0, 0);

        // Random vectors against the reference model.
        for (int r = 0; r < 40; r++) begin
            int n;
            int full;
            logic [15:0] b;
            n    = $urandom_range(1, 8);
            full = $urandom_range(0, 3);
            qx.delete();
            qw.delete();
            qg.delete();
            for (int i = 0; i < n; i++) begin
                if (full == 0) begin
                    qx.push_back(16'($urandom));
                    qw.push_back(16'($urandom));
                end else begin
                    qx.push_back(16'($signed(12'($urandom))));
                    qw.push_back(16'($signed(10'($urandom))));
                end
                qg.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
            end
            b = (full == 0) ? 16'($urandom) : 16'($signed(12'($urandom)));
            ref_model(b, ed, es);
            send_vec("rand", b);
            finish_vec("rand", ed, es, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
